// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port RAM arbiter.
// State codes, grant encoding, defaults and the fixed IF fetch request shape.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_BUSY = 2'b01,
    ARB_DONE = 2'b10
  } arb_state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  localparam int          DEF_STARVE_LIMIT = 4;
  localparam int          DEF_TIMEOUT      = 16;
  localparam logic        CHIP_ENABLE      = 1'b1;
  localparam logic        CHIP_DISABLE     = 1'b0;
  localparam logic        WRITE_DISABLE    = 1'b0;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [3:0]  SEL_WORD         = 4'b1111;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } ram_req_t;

  // Instruction fetches are always full-word reads.
  function automatic ram_req_t if_fetch_req(input logic [31:0] addr);
    ram_req_t r;
    r.we   = WRITE_DISABLE;
    r.addr = addr;
    r.sel  = SEL_WORD;
    r.data = ZERO_WORD;
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_priority.sv
// Grant selection between IF and MEM with a saturating IF-starvation counter.
// The counter only moves while the arbiter is idle (en=1).
module arb_priority
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   if_req,
  input  logic   mem_req,
  output grant_e grant,
  output logic   grant_valid
);

  localparam int              SC_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt;
  logic            if_forced;

  always_comb begin
    if_forced   = if_req && (starve_cnt == SC_MAX);
    grant_valid = if_req || mem_req;
    grant       = (mem_req && !if_forced) ? GRANT_MEM : GRANT_IF;
  end

  // Counts MEM wins that left IF waiting; any IF win or IF going quiet resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (en) begin
      if (!if_req || grant == GRANT_IF) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SC_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and load/store.
// One registered transaction at a time: IDLE -> BUSY (wait ack/timeout) -> DONE.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stallreq_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  input  logic        ram_ack_i,
  output logic        bus_err_o,
  output logic [1:0]  dbg_state
);

  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  arb_state_e       state, state_next;
  grant_e           grant, winner;
  logic             grant_valid;
  ram_req_t         req_sel;
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_hit, start, finish_ack, finish_tmo;
  logic             done_if, done_mem;

  arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .clk        (clk),
    .rst        (rst),
    .en         (state == ARB_IDLE),
    .if_req     (if_ce_i),
    .mem_req    (mem_ce_i),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  always_comb begin
    if (grant == GRANT_IF) begin
      req_sel = if_fetch_req(if_addr_i);
    end else begin
      req_sel = '{we: mem_we_i, addr: mem_addr_i, sel: mem_sel_i, data: mem_data_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An ack on the last allowed BUSY cycle wins over the timeout.
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    finish_ack  = 1'b0;
    finish_tmo  = 1'b0;
    timeout_hit = (tmo_cnt == TMO_LAST);
    case (state)
      ARB_IDLE: begin
        if (grant_valid) begin
          start      = 1'b1;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (ram_ack_i) begin
          finish_ack = 1'b1;
          state_next = ARB_DONE;
        end else if (timeout_hit) begin
          finish_tmo = 1'b1;
          state_next = ARB_DONE;
        end
      end
      ARB_DONE: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner     <= GRANT_IF;
      tmo_cnt    <= '0;
      ram_ce_o   <= CHIP_DISABLE;
      ram_we_o   <= WRITE_DISABLE;
      ram_addr_o <= ZERO_WORD;
      ram_sel_o  <= '0;
      ram_data_o <= ZERO_WORD;
      if_data_o  <= ZERO_WORD;
      mem_data_o <= ZERO_WORD;
      bus_err_o  <= 1'b0;
    end else begin
      bus_err_o <= finish_tmo;
      if (start) begin
        winner     <= grant;
        tmo_cnt    <= '0;
        ram_ce_o   <= CHIP_ENABLE;
        ram_we_o   <= req_sel.we;
        ram_addr_o <= req_sel.addr;
        ram_sel_o  <= req_sel.sel;
        ram_data_o <= req_sel.data;
      end else if (state == ARB_BUSY && !finish_ack && !finish_tmo) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (finish_ack || finish_tmo) begin
        ram_ce_o   <= CHIP_DISABLE;
        ram_we_o   <= WRITE_DISABLE;
        ram_addr_o <= ZERO_WORD;
        ram_sel_o  <= '0;
        ram_data_o <= ZERO_WORD;
      end
      // A requester that dropped ce mid-cycle no longer wants the result.
      if (finish_ack && !ram_we_o) begin
        if (winner == GRANT_IF && if_ce_i) begin
          if_data_o <= ram_data_i;
        end else if (winner == GRANT_MEM && mem_ce_i) begin
          mem_data_o <= ram_data_i;
        end
      end
      if (finish_tmo) begin
        if (winner == GRANT_IF && if_ce_i) begin
          if_data_o <= ZERO_WORD;
        end else if (winner == GRANT_MEM && mem_ce_i) begin
          mem_data_o <= ZERO_WORD;
        end
      end
    end
  end

  always_comb begin
    done_if        = (state == ARB_DONE) && (winner == GRANT_IF);
    done_mem       = (state == ARB_DONE) && (winner == GRANT_MEM);
    if_stallreq_o  = if_ce_i & ~done_if;
    mem_stallreq_o = mem_ce_i & ~done_mem;
    dbg_state      = state;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: load, store+fetch ordering, starvation,
// timeout, ack-on-timeout and asynchronous reset while busy.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        mem_ce_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] mem_data_o;
  logic        mem_stallreq_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i = '0;
  logic        ram_ack_i = 1'b0;
  logic        bus_err_o;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  mem_bus_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .if_ce_i       (if_ce_i),
    .if_addr_i     (if_addr_i),
    .if_data_o     (if_data_o),
    .if_stallreq_o (if_stallreq_o),
    .mem_ce_i      (mem_ce_i),
    .mem_we_i      (mem_we_i),
    .mem_addr_i    (mem_addr_i),
    .mem_sel_i     (mem_sel_i),
    .mem_data_i    (mem_data_i),
    .mem_data_o    (mem_data_o),
    .mem_stallreq_o(mem_stallreq_o),
    .ram_ce_o      (ram_ce_o),
    .ram_we_o      (ram_we_o),
    .ram_addr_o    (ram_addr_o),
    .ram_sel_o     (ram_sel_o),
    .ram_data_o    (ram_data_o),
    .ram_data_i    (ram_data_i),
    .ram_ack_i     (ram_ack_i),
    .bus_err_o     (bus_err_o),
    .dbg_state     (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_ram_ce(input int max_cyc);
    int n;
    n = 0;
    while (!ram_ce_o && n < max_cyc) begin
      step();
      n++;
    end
    check("ram_ce_wait", {31'b0, ram_ce_o}, 32'h1);
  endtask

  // Called on the first negedge where ram_ce_o is seen; acks d cycles later.
  task automatic respond(input int d, input logic [31:0] data);
    repeat (d) step();
    ram_ack_i  = 1'b1;
    ram_data_i = data;
    step();
    ram_ack_i  = 1'b0;
  endtask

  initial begin
    logic ce_prev;
    int   grants;

    // Reset state
    #12;
    check("rst_ram_ce", {31'b0, ram_ce_o}, 32'h0);
    check("rst_ram_addr", ram_addr_o, 32'h0);
    check("rst_if_data", if_data_o, 32'h0);
    check("rst_mem_data", mem_data_o, 32'h0);
    check("rst_bus_err", {31'b0, bus_err_o}, 32'h0);
    check("rst_state", {30'b0, dbg_state}, ARB_IDLE);
    step();
    rst = 1'b0;

    // MEM load alone, ack 2 cycles after ram_ce_o
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h100; mem_sel_i = 4'b1111;
    step();
    check("ld_ram_ce", {31'b0, ram_ce_o}, 32'h1);
    check("ld_ram_addr", ram_addr_o, 32'h100);
    check("ld_ram_sel", {28'b0, ram_sel_o}, 32'hF);
    check("ld_ram_we", {31'b0, ram_we_o}, 32'h0);
    check("ld_stall_busy", {31'b0, mem_stallreq_o}, 32'h1);
    respond(2, 32'hDEADBEEF);
    check("ld_state_done", {30'b0, dbg_state}, ARB_DONE);
    check("ld_stall_done", {31'b0, mem_stallreq_o}, 32'h0);
    check("ld_data", mem_data_o, 32'hDEADBEEF);
    check("ld_ram_ce_off", {31'b0, ram_ce_o}, 32'h0);
    step();
    check("ld_stall_after", {31'b0, mem_stallreq_o}, 32'h1);
    mem_ce_i = 1'b0;
    check("ld_data_hold", mem_data_o, 32'hDEADBEEF);

    // Simultaneous IF fetch and MEM store: MEM first
    if_ce_i = 1'b1; if_addr_i = 32'h4;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h300;
    mem_sel_i = 4'b0011; mem_data_i = 32'h12345678;
    wait_ram_ce(4);
    check("st_ram_we", {31'b0, ram_we_o}, 32'h1);
    check("st_ram_addr", ram_addr_o, 32'h300);
    check("st_ram_data", ram_data_o, 32'h12345678);
    check("st_ram_sel", {28'b0, ram_sel_o}, 32'h3);
    check("st_if_stall", {31'b0, if_stallreq_o}, 32'h1);
    respond(1, 32'h0BADF00D);
    check("st_mem_stall_done", {31'b0, mem_stallreq_o}, 32'h0);
    check("st_if_stall_done", {31'b0, if_stallreq_o}, 32'h1);
    check("st_mem_data_kept", mem_data_o, 32'hDEADBEEF);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    step();
    check("if_stall_idle", {31'b0, if_stallreq_o}, 32'h1);
    wait_ram_ce(4);
    check("if_ram_addr", ram_addr_o, 32'h4);
    check("if_ram_we", {31'b0, ram_we_o}, 32'h0);
    check("if_ram_sel", {28'b0, ram_sel_o}, 32'hF);
    check("if_stall_busy", {31'b0, if_stallreq_o}, 32'h1);
    respond(1, 32'h3C000013);
    check("if_stall_done", {31'b0, if_stallreq_o}, 32'h0);
    check("if_data", if_data_o, 32'h3C000013);
    if_ce_i = 1'b0;
    step();

    // Starvation: both held, expect MEM x4, IF, MEM x4, IF
    for (int k = 0; k < 2; k++) begin
      repeat (4) exp_q.push_back(32'h200);
      exp_q.push_back(32'h4);
    end
    if_ce_i = 1'b1; if_addr_i = 32'h4;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h200; mem_sel_i = 4'b1111;
    ce_prev = 1'b0;
    grants = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      step();
      ram_ack_i  = ram_ce_o && !ram_ack_i;
      ram_data_i = 32'h5A5A0000 | ram_addr_o;
      if (ram_ce_o && !ce_prev) begin
        grants++;
        if (exp_q.size() > 0) check("grant_seq", ram_addr_o, exp_q.pop_front());
        else check("grant_extra", 32'(grants), 32'd10);
        if (grants == 10) begin
          if_ce_i = 1'b0;
          mem_ce_i = 1'b0;
        end
      end
      ce_prev = ram_ce_o;
      if (grants >= 10 && dbg_state == ARB_IDLE && !ram_ce_o) break;
    end
    ram_ack_i = 1'b0;
    check("grant_remaining", 32'(exp_q.size()), 32'd0);
    check("starve_end_idle", {30'b0, dbg_state}, ARB_IDLE);

    // Timeout: 16 BUSY cycles with no ack
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h400;
    wait_ram_ce(4);
    repeat (15) step();
    check("tmo_still_busy", {30'b0, dbg_state}, ARB_BUSY);
    check("tmo_no_err_yet", {31'b0, bus_err_o}, 32'h0);
    step();
    check("tmo_state_done", {30'b0, dbg_state}, ARB_DONE);
    check("tmo_bus_err", {31'b0, bus_err_o}, 32'h1);
    check("tmo_data_zero", mem_data_o, 32'h0);
    check("tmo_ram_ce_off", {31'b0, ram_ce_o}, 32'h0);
    check("tmo_stall_done", {31'b0, mem_stallreq_o}, 32'h0);
    mem_ce_i = 1'b0;
    step();
    check("tmo_err_pulse", {31'b0, bus_err_o}, 32'h0);
    check("tmo_idle", {30'b0, dbg_state}, ARB_IDLE);
    ram_ack_i = 1'b1; ram_data_i = 32'hBADBAD00;
    step();
    ram_ack_i = 1'b0;
    check("late_ack_idle", {30'b0, dbg_state}, ARB_IDLE);
    check("late_ack_ce", {31'b0, ram_ce_o}, 32'h0);
    check("late_ack_data", mem_data_o, 32'h0);

    // Ack arriving on the last allowed BUSY cycle
    mem_ce_i = 1'b1; mem_addr_i = 32'h500;
    wait_ram_ce(4);
    repeat (15) step();
    ram_ack_i = 1'b1; ram_data_i = 32'hCAFEF00D;
    step();
    ram_ack_i = 1'b0;
    check("race_state_done", {30'b0, dbg_state}, ARB_DONE);
    check("race_no_err", {31'b0, bus_err_o}, 32'h0);
    check("race_data", mem_data_o, 32'hCAFEF00D);
    mem_ce_i = 1'b0;
    step();

    // Asynchronous reset in the middle of a BUSY cycle
    if_ce_i = 1'b1; if_addr_i = 32'h4;
    mem_ce_i = 1'b1; mem_addr_i = 32'h600;
    wait_ram_ce(4);
    check("rb_ram_addr", ram_addr_o, 32'h600);
    step();
    #2 rst = 1'b1;
    #1;
    check("rb_ram_ce", {31'b0, ram_ce_o}, 32'h0);
    check("rb_state", {30'b0, dbg_state}, ARB_IDLE);
    check("rb_mem_data", mem_data_o, 32'h0);
    check("rb_mem_stall", {31'b0, mem_stallreq_o}, 32'h1);
    #1 rst = 1'b0;
    wait_ram_ce(4);
    check("rb_restart_addr", ram_addr_o, 32'h600);
    respond(0, 32'h600D600D);
    check("rb_mem_data_done", mem_data_o, 32'h600D600D);
    check("rb_if_stall", {31'b0, if_stallreq_o}, 32'h1);
    mem_ce_i = 1'b0;
    wait_ram_ce(4);
    check("rb_if_addr", ram_addr_o, 32'h4);
    respond(0, 32'h00000013);
    check("rb_if_data", if_data_o, 32'h00000013);
    if_ce_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported data/instruction RAM port between the instruction-fetch requester (IF) and the load/store requester (MEM stage).
- Grants one transaction at a time and drives the RAM bus from registers.
- Waits for the RAM acknowledge, returns read data to the winning requester, and raises per-requester stall requests to the pipeline control block until that requester's access completes.
- Sits between the IF/MEM stages and the external RAM interface.

Parameters:
- STARVE_LIMIT, 4: number of consecutive MEM grants while IF is pending before IF is forced to win the next arbitration.
- TIMEOUT, 16: BUSY cycles without ram_ack_i before the transaction is aborted with an error.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high (`RstEnable)
- if_ce_i  in  1  IF fetch request
- if_addr_i  in  32  fetch byte address
- if_data_o  out  32  fetched instruction, valid when if_ce_i=1 and if_stallreq_o=0
- if_stallreq_o  out  1  IF must hold its request
- mem_ce_i  in  1  MEM access request
- mem_we_i  in  1  1 = store
- mem_addr_i  in  32  data byte address
- mem_sel_i  in  4  byte lane enables
- mem_data_i  in  32  store data
- mem_data_o  out  32  load data, valid when mem_ce_i=1 and mem_stallreq_o=0
- mem_stallreq_o  out  1  MEM must hold its request
- ram_ce_o  out  1  RAM cycle active
- ram_we_o  out  1  RAM write
- ram_addr_o  out  32  RAM address
- ram_sel_o  out  4  RAM lane enables
- ram_data_o  out  32  RAM write data
- ram_data_i  in  32  RAM read data, valid with ram_ack_i
- ram_ack_i  in  1  RAM completion, one-cycle pulse
- bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, immediate): FSM=IDLE.
  - All ram_* outputs, if_data_o, mem_data_o and bus_err_o are 0; starvation and timeout counters are 0; stalls follow the combinational rule below.
  - A transaction in flight is dropped; no ack is consumed after reset.
- FSM IDLE: if any request is present, register the winner's address/sel/data/we onto ram_*, set ram_ce_o=1 and go to BUSY.
  - IF requests always force ram_we_o=0 and ram_sel_o=4'b1111.
- Arbitration (in IDLE only):
  - MEM wins over IF, except when starve_cnt==STARVE_LIMIT and IF is pending; then IF wins.
  - starve_cnt increments on each MEM grant while if_ce_i=1, saturating at STARVE_LIMIT.
  - starve_cnt clears on any IF grant, or when if_ce_i=0 in IDLE.
- FSM BUSY: ram_* outputs are held stable; the timeout counter increments each cycle.
  - On ram_ack_i=1: latch ram_data_i (reads only) into the winner's data register, drop ram_ce_o, go to DONE.
  - On the timeout counter reaching TIMEOUT without ack: drop ram_ce_o, load the winner's data register with 0, pulse bus_err_o, go to DONE.
  - An ack and the timeout in the same cycle count as an ack; no error.
- FSM DONE (exactly 1 cycle): the winner's stallreq=0 and its data output is valid. Next state is IDLE.
  - Data registers hold their value until the next completion for the same requester.
- Stall rule (combinational): X_stallreq_o = X_ce_i & ~(state==DONE & winner==X).
  - Requesters must hold ce/addr/we/sel/data stable while stalled.
  - Dropping ce mid-transaction does not abort the RAM cycle; the result is discarded.
- Latency: request in IDLE cycle N → ram_ce_o=1 in N+1 → ack at cycle A ≥ N+1 → DONE at A+1. Minimum 3 cycles per access; throughput is one access per 3 cycles at best.
- ram_ack_i outside BUSY is ignored.
- Simultaneous new requests during BUSY/DONE are queued implicitly by the stall; no internal FIFO.

Decomposition:
- define.v additions: `ArbIdle/`ArbBusy/`ArbDone 2-bit state codes, `GrantIf/`GrantMem, default STARVE_LIMIT/TIMEOUT values, reusing `ChipEnable/`WriteEnable/`ZeroWord.
- One sub-module: arb_priority. Combinational grant select plus the saturating starvation counter, enabled only in IDLE.

Test Plan:
- MEM load alone: mem_ce_i=1, we=0, addr=0x100, RAM acks 2 cycles after ram_ce_o → ram_addr_o=0x100, ram_sel_o=mem_sel_i; mem_data_o=ram_data_i (0xDEADBEEF) with mem_stallreq_o=0 exactly one cycle, 4 cycles after the request.
- Simultaneous IF+MEM, one request each: MEM is served first (ram_we_o per store, data 0x12345678, sel 4'b0011), then IF at addr 0x4; if_stallreq_o stays high until the IF DONE cycle.
- Starvation: IF and MEM held continuously, STARVE_LIMIT=4 → grant sequence MEM×4, IF, MEM×4, IF…
- Timeout: no ack for 16 BUSY cycles → bus_err_o pulses once, winner's data=0x00000000, FSM back to IDLE; a late ack afterwards is ignored.
- Reset mid-BUSY: assert rst asynchronously between clock edges → ram_ce_o=0 immediately, state IDLE; after release, a pending request restarts from IDLE with fresh arbitration.
- Ack and timeout in the same cycle → treated as success, bus_err_o stays 0, data = ram_data_i.
